// File: rtl/pc_sequencer_pkg.sv
// Shared types for the PC sequencer: FSM states, PC control codes and redirect kinds.
package pc_sequencer_pkg;

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_EXEC  = 3'd3,
    S_STEP  = 3'd4,
    S_JUMP  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    PC_HOLD = 2'b00,
    PC_ADD  = 2'b01,
    PC_INC  = 2'b10,
    PC_LOAD = 2'b11
  } pc_ctrl_t;

  typedef enum logic [1:0] {
    REDIR_REL  = 2'b00,
    REDIR_ABS  = 2'b01,
    REDIR_CALL = 2'b10,
    REDIR_RET  = 2'b11
  } redir_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle of PC, instruction-memory, decode and execute lines around the sequencer.
interface pc_sequencer_if #(
  parameter int a_width = 8,
  parameter int d_width = 16
);
  logic [a_width-1:0] pc_in;
  logic [1:0]         pc_ctrl;
  logic [a_width-1:0] pc_ld;
  logic               pc_clr_n;
  logic               imem_req;
  logic [a_width-1:0] imem_addr;
  logic               imem_ack;
  logic [d_width-1:0] imem_data;
  logic               instr_valid;
  logic [d_width-1:0] instr_out;
  logic               instr_ready;
  logic               exec_done;
  logic               redir_valid;
  logic [1:0]         redir_type;
  logic [a_width-1:0] redir_addr;
  logic               stk_err;

  modport master (
    input  pc_in, imem_ack, imem_data, instr_ready,
           exec_done, redir_valid, redir_type, redir_addr,
    output pc_ctrl, pc_ld, pc_clr_n, imem_req, imem_addr,
           instr_valid, instr_out, stk_err
  );

  modport slave (
    output pc_in, imem_ack, imem_data, instr_ready,
           exec_done, redir_valid, redir_type, redir_addr,
    input  pc_ctrl, pc_ld, pc_clr_n, imem_req, imem_addr,
           instr_valid, instr_out, stk_err
  );
endinterface

// File: rtl/pc_sequencer_ras_stack.sv
// Return-address LIFO: push writes at sp then increments, pop reads sp-1 then decrements.
module ras_stack #(
  parameter int stack_depth = 4,
  parameter int a_width     = 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               push,
  input  logic               pop,
  input  logic [a_width-1:0] din,
  output logic [a_width-1:0] dout,
  output logic               full,
  output logic               empty
);
  localparam int PTR_W = $clog2(stack_depth);

  logic [a_width-1:0] mem [stack_depth];
  logic [PTR_W:0]     cnt;
  logic [PTR_W-1:0]   wr_idx;
  logic [PTR_W-1:0]   rd_idx;

  assign wr_idx = cnt[PTR_W-1:0];
  assign rd_idx = wr_idx - PTR_W'(1);
  assign full   = (cnt == (PTR_W+1)'(stack_depth));
  assign empty  = (cnt == '0);
  assign dout   = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + (PTR_W+1)'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - (PTR_W+1)'(1);
    end
  end

  // NOTE: storage has no reset; the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_idx] <= din;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Serial fetch / issue / execute sequencer driving the PC control lines, with a return stack.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int a_width     = 8,
  parameter int d_width     = 16,
  parameter int stack_depth = 4
) (
  input  logic              clk,
  input  logic              clr,
  pc_sequencer_if.master    bus
);

  state_t             state_q, state_d;
  pc_ctrl_t           pc_ctrl_q, pc_ctrl_d;
  logic [a_width-1:0] pc_ld_q, pc_ld_d;
  logic [a_width-1:0] imem_addr_q, imem_addr_d;
  logic               imem_req_q, imem_req_d;
  logic               instr_valid_q, instr_valid_d;
  logic [d_width-1:0] instr_q, instr_d;
  logic               stk_err_q, stk_err_d;

  logic               ras_push, ras_pop, ras_full, ras_empty;
  logic [a_width-1:0] ras_din, ras_dout;
  redir_t             rtype;

  assign rtype   = redir_t'(bus.redir_type);
  assign ras_din = bus.pc_in + a_width'(1);

  ras_stack #(
    .stack_depth (stack_depth),
    .a_width     (a_width)
  ) u_ras (
    .clk   (clk),
    .clr   (clr),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (ras_din),
    .dout  (ras_dout),
    .full  (ras_full),
    .empty (ras_empty)
  );

  // Output registers are loaded with the values belonging to the state being entered,
  // so every registered output lines up with state_q.
  // NOTE: every signal gets a default before the case, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d       = state_q;
    pc_ctrl_d     = PC_HOLD;
    pc_ld_d       = pc_ld_q;
    imem_addr_d   = imem_addr_q;
    imem_req_d    = imem_req_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    stk_err_d     = stk_err_q;
    ras_push      = 1'b0;
    ras_pop       = 1'b0;

    case (state_q)
      S_RESET: state_d = S_FETCH;

      // First FETCH cycle latches the freshly updated PC; the request then holds until ack.
      S_FETCH: begin
        if (!imem_req_q) begin
          imem_req_d  = 1'b1;
          imem_addr_d = bus.pc_in;
        end else if (bus.imem_ack) begin
          imem_req_d    = 1'b0;
          instr_d       = bus.imem_data;
          instr_valid_d = 1'b1;
          state_d       = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (bus.instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = S_EXEC;
        end
      end

      S_EXEC: begin
        if (bus.redir_valid) begin
          state_d = S_JUMP;
          case (rtype)
            REDIR_REL: begin
              pc_ctrl_d = PC_ADD;
              pc_ld_d   = bus.redir_addr;
            end
            REDIR_ABS: begin
              pc_ctrl_d = PC_LOAD;
              pc_ld_d   = bus.redir_addr;
            end
            REDIR_CALL: begin
              pc_ctrl_d = PC_LOAD;
              pc_ld_d   = bus.redir_addr;
              if (ras_full) stk_err_d = 1'b1;
              else          ras_push  = 1'b1;
            end
            REDIR_RET: begin
              if (ras_empty) begin
                stk_err_d = 1'b1;
                pc_ctrl_d = PC_INC;
              end else begin
                ras_pop   = 1'b1;
                pc_ctrl_d = PC_LOAD;
                pc_ld_d   = ras_dout;
              end
            end
            default: state_d = S_JUMP;
          endcase
        end else if (bus.exec_done) begin
          state_d   = S_STEP;
          pc_ctrl_d = PC_INC;
        end
      end

      S_STEP,
      S_JUMP: state_d = S_FETCH;

      default: state_d = S_RESET;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q       <= S_RESET;
      pc_ctrl_q     <= PC_HOLD;
      pc_ld_q       <= '0;
      imem_addr_q   <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      stk_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_ctrl_q     <= pc_ctrl_d;
      pc_ld_q       <= pc_ld_d;
      imem_addr_q   <= imem_addr_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      stk_err_q     <= stk_err_d;
    end
  end

  assign bus.pc_ctrl     = pc_ctrl_q;
  assign bus.pc_ld       = pc_ld_q;
  assign bus.pc_clr_n    = ~clr;
  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = imem_addr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr_out   = instr_q;
  assign bus.stk_err     = stk_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench: external PC register, memory/decode/execute stimulus and an instruction-level model.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int SD = 4;
  localparam int K_STEP = 4;  // kinds 0..3 are redirect types

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  pc_sequencer_if #(.a_width(AW), .d_width(DW)) bus ();

  pc_sequencer #(.a_width(AW), .d_width(DW), .stack_depth(SD)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // External PC register controlled by the sequencer.
  logic [AW-1:0] pc_reg;
  always @(posedge clk) begin
    if (!bus.pc_clr_n) pc_reg <= '0;
    else begin
      case (bus.pc_ctrl)
        2'b01:   pc_reg <= pc_reg + bus.pc_ld;
        2'b10:   pc_reg <= pc_reg + 8'd1;
        2'b11:   pc_reg <= bus.pc_ld;
        default: pc_reg <= pc_reg;
      endcase
    end
  end
  assign bus.pc_in = pc_reg;

  // Instruction-level reference model.
  logic [AW-1:0] model_pc;
  logic [AW-1:0] model_stack[$];
  logic          model_err;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_noise();
    bus.exec_done   = 1'($urandom_range(0, 1));
    bus.redir_valid = 1'($urandom_range(0, 1));
    bus.redir_type  = 2'($urandom);
    bus.redir_addr  = 8'($urandom);
  endtask

  task automatic clear_exec();
    bus.exec_done   = 1'b0;
    bus.redir_valid = 1'b0;
    bus.redir_type  = 2'b00;
    bus.redir_addr  = '0;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    clear_exec();
    repeat (2) @(negedge clk);
    check("rst_req",     bus.imem_req,    0);
    check("rst_addr",    bus.imem_addr,   0);
    check("rst_valid",   bus.instr_valid, 0);
    check("rst_instr",   bus.instr_out,   0);
    check("rst_ctrl",    bus.pc_ctrl,     0);
    check("rst_ld",      bus.pc_ld,       0);
    check("rst_err",     bus.stk_err,     0);
    check("rst_clr_n",   bus.pc_clr_n,    0);
    clr = 1'b0;
    model_pc  = '0;
    model_stack.delete();
    model_err = 1'b0;
  endtask

  // One full instruction: fetch, issue, execute, then the STEP/JUMP cycle.
  task automatic run_instr(input int ack_dly, input int rdy_dly, input int ex_dly,
                           input int kind, input logic [AW-1:0] arg,
                           input logic [DW-1:0] word, input bit both);
    bit            seen, stable;
    logic [AW-1:0] addr0, exp_ld;
    logic [1:0]    exp_ctrl;
    bit            chk_ld;

    seen = 1'b0;
    @(negedge clk);
    check("ctrl_idle", bus.pc_ctrl, 0);
    check("clr_n_high", bus.pc_clr_n, 1);
    for (int i = 0; i < 8; i++) begin
      if (bus.imem_req) begin
        seen = 1'b1;
        break;
      end
      drive_noise();
      @(negedge clk);
    end
    check("req_seen", seen, 1);
    if (!seen) return;
    check("fetch_addr", bus.imem_addr, model_pc);

    addr0  = bus.imem_addr;
    stable = 1'b1;
    repeat (ack_dly) begin
      drive_noise();
      @(negedge clk);
      if (!bus.imem_req || bus.imem_addr !== addr0 || bus.instr_valid) stable = 1'b0;
    end
    check("req_stable", stable, 1);

    bus.imem_ack  = 1'b1;
    bus.imem_data = word;
    drive_noise();
    @(negedge clk);
    bus.imem_ack  = 1'b0;
    bus.imem_data = 16'($urandom);
    check("req_drop",  bus.imem_req,    0);
    check("valid_up",  bus.instr_valid, 1);
    check("instr_out", bus.instr_out,   word);

    stable = 1'b1;
    repeat (rdy_dly) begin
      drive_noise();
      @(negedge clk);
      if (!bus.instr_valid || bus.instr_out !== word || bus.pc_ctrl !== 2'b00) stable = 1'b0;
    end
    check("valid_hold", stable, 1);

    bus.instr_ready = 1'b1;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    clear_exec();
    check("valid_drop", bus.instr_valid, 0);

    stable = 1'b1;
    repeat (ex_dly) begin
      @(negedge clk);
      if (bus.pc_ctrl !== 2'b00) stable = 1'b0;
    end
    check("exec_hold", stable, 1);

    chk_ld = 1'b1;
    exp_ld = arg;
    if (kind == K_STEP) begin
      bus.exec_done = 1'b1;
      exp_ctrl = 2'b10;
      chk_ld   = 1'b0;
      model_pc = model_pc + 8'd1;
    end else begin
      bus.redir_valid = 1'b1;
      bus.redir_type  = 2'(kind);
      bus.redir_addr  = arg;
      bus.exec_done   = both;
      case (kind)
        0: begin exp_ctrl = 2'b01; model_pc = model_pc + arg; end
        1: begin exp_ctrl = 2'b11; model_pc = arg; end
        2: begin
          exp_ctrl = 2'b11;
          if (model_stack.size() < SD) model_stack.push_back(model_pc + 8'd1);
          else                         model_err = 1'b1;
          model_pc = arg;
        end
        default: begin
          if (model_stack.size() == 0) begin
            model_err = 1'b1;
            exp_ctrl  = 2'b10;
            chk_ld    = 1'b0;
            model_pc  = model_pc + 8'd1;
          end else begin
            exp_ctrl = 2'b11;
            exp_ld   = model_stack.pop_back();
            model_pc = exp_ld;
          end
        end
      endcase
    end
    @(negedge clk);
    clear_exec();
    check("pc_ctrl", bus.pc_ctrl, exp_ctrl);
    if (chk_ld) check("pc_ld", bus.pc_ld, exp_ld);
    check("stk_err", bus.stk_err, model_err);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen;
    clr             = 1'b1;
    bus.imem_ack    = 1'b0;
    bus.imem_data   = '0;
    bus.instr_ready = 1'b0;
    clear_exec();

    do_reset();
    // Basic step, then a slow ack / slow decode step.
    run_instr(0, 0, 0, K_STEP, 8'h00, 16'h1234, 1'b0);
    run_instr(3, 2, 1, K_STEP, 8'h00, 16'hBEEF, 1'b0);
    // Relative redirect wrapping past the top of the address space.
    run_instr(0, 0, 0, 1, 8'hFE, 16'h0001, 1'b0);
    run_instr(1, 0, 0, 0, 8'h05, 16'h0002, 1'b0);
    // Call then return.
    run_instr(0, 0, 0, 1, 8'h10, 16'h0003, 1'b0);
    run_instr(0, 1, 0, 2, 8'h40, 16'h0004, 1'b0);
    run_instr(0, 0, 2, 3, 8'h00, 16'h0005, 1'b0);
    check("stack_empty", model_stack.size(), 0);
    // Overflow on the fifth call, drain, then underflow.
    for (int i = 0; i < 5; i++) run_instr(0, 0, 0, 2, 8'(8'h20 + 8'(i * 16)), 16'(i), 1'b0);
    for (int i = 0; i < 5; i++) run_instr(0, 0, 0, 3, 8'h00, 16'(16'h100 + i), 1'b0);
    run_instr(0, 0, 0, K_STEP, 8'h00, 16'h0BAD, 1'b0);

    // Reset while a fetch is in flight.
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.imem_req) begin
        seen = 1'b1;
        break;
      end
    end
    check("mid_fetch_req", seen, 1);
    do_reset();
    // Redirect together with exec_done: redirect wins.
    run_instr(0, 0, 0, 1, 8'h77, 16'hCAFE, 1'b1);
    run_instr(0, 0, 0, K_STEP, 8'h00, 16'hF00D, 1'b0);

    // Randomized instruction stream.
    for (int n = 0; n < 150; n++) begin
      run_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 4), 8'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
